bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from each BCD nibble ≥ 8.
- It is the inverse of the binary-to-BCD path that feeds the 7-segment display.
- Use: decimal operands entered digit-wise on switches are converted to binary before they are loaded into the adder/subtractor.
- Start/busy/done handshake; one iteration per clock.

Parameters:
- DIGITS, 4, number of BCD digits on input.
- BIN_W, 14, binary result width and iteration count; must satisfy 2^BIN_W > 10^DIGITS − 1 (14 for 4 digits).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request conversion of bcd; sampled only in IDLE.
- bcd  in  4*DIGITS  packed BCD operand, digit 0 in bits [3:0].
- busy  out  1  high while converting.
- done  out  1  one-cycle pulse when a conversion or rejection completes.
- bin  out  BIN_W  last converted value; held between conversions.
- err  out  1  invalid-digit flag for the last request; held until the next done.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, bin=0, err=0; iteration counter=0; shift register=0.
- State IDLE:
  - start=1 at edge k: shift register loads {bcd, BIN_W'b0}, counter=0, state=CONV.
  - busy=1 from after edge k.
  - start=0: remain in IDLE, done=0.
- State CONV, each edge:
  - Shift the whole register right by 1.
  - Then, for every BCD nibble of the shifted value, if nibble ≥ 8, nibble −= 3.
  - Counter increments.
- Completion: on the edge that performs iteration BIN_W (edge k+BIN_W):
  - bin <= low BIN_W bits of the result, err <= 0, done <= 1 for exactly one cycle, busy <= 0, state=IDLE.
  - Latency is BIN_W clocks from the start edge to done visible, i.e. 14 by default.
- start while busy: ignored, with no queueing.
- start high on the cycle done is high: accepted, since the state is already IDLE. The next conversion begins and done falls on the following cycle.
- start held high continuously: back-to-back conversions, one every BIN_W+1 cycles.
- bcd is sampled only at the start edge; later changes have no effect on the running conversion.
- bin and err change only on the done edge. Between done pulses, bin is stable and always reflects the last completed request.
- BCD field is all zero after BIN_W iterations for every legal input; this is not exported, but the bench may check it internally.
- rst_n asserted mid-conversion: immediate abort to reset values. No done pulse is produced for the aborted request.

Optional Feature:
- Macro: BCD2BIN_DIGIT_CHECK_EN
- With the macro defined:
  - At the start edge, any nibble of bcd > 9 rejects the request: state stays IDLE, busy stays 0.
  - On the next edge, done=1 for one cycle, err=1, bin unchanged.
  - Legal requests behave as above, with err=0.
- Without the macro:
  - err is tied to 0.
  - Every request is converted by the algorithm regardless of digit legality; the result for illegal digits is deterministic but unspecified and is not checked.

Test Plan:
- Reset, then bcd=16'h0255 with a 1-cycle start -> busy=1 for 14 cycles; done pulses once; bin=14'd255 (0x00FF); err=0.
- bcd=16'h9999, start -> bin=14'd9999 (0x270F) after 14 cycles.
- bcd=16'h0000, then bcd=16'h0001 back-to-back with start held -> bin=0, then bin=1; exactly 15 cycles between done pulses.
- Start a conversion of 16'h1234; pulse start with bcd=16'h4321 at cycle 5 of busy -> second start ignored; bin=1234; only one done.
- Start a conversion of 16'h0500; assert rst_n=0 at cycle 7 -> busy/done/bin/err drop to 0 immediately; no done after release.
- BCD2BIN_DIGIT_CHECK_EN defined, bin previously 255, bcd=16'h12A4 with start -> done on the next cycle, err=1, bin=255, busy never high.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// ============================================================================
// bcd_to_bin_seq : sequential BCD-to-binary converter (reverse double-dabble),
//                  one iteration per clock, start/busy/done handshake.
// Optional digit-legality check: define BCD2BIN_DIGIT_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_SR_W  = c_BCD_W + BIN_W;
  localparam int c_CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_REJ  = 2'd2
  } state_t;

  state_t              state_q;
  logic [c_SR_W-1:0]   sr_q;
  logic [c_SR_W-1:0]   sr_shift;
  logic [c_SR_W-1:0]   sr_d;
  logic [c_CNT_W-1:0]  cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [BIN_W-1:0]    bin_q;
  logic                err_q;
  logic                bad_digit;

  // One iteration: shift right, then pull every BCD nibble >= 8 back by 3.
  assign sr_shift           = sr_q >> 1;
  assign sr_d[BIN_W-1:0]    = sr_shift[BIN_W-1:0];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    logic [3:0] nib;
    assign nib                     = sr_shift[BIN_W+4*gi +: 4];
    assign sr_d[BIN_W+4*gi +: 4]   = (nib >= 4'd8) ? (nib - 4'd3) : nib;
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic [DIGITS-1:0] digit_bad;
  for (genvar gd = 0; gd < DIGITS; gd++) begin : g_chk
    assign digit_bad[gd] = (bcd[4*gd +: 4] > 4'd9);
  end
  assign bad_digit = |digit_bad;
`else
  assign bad_digit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && bad_digit) begin
            state_q <= S_REJ;
          end else if (start) begin
            sr_q    <= {bcd, {BIN_W{1'b0}}};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == c_CNT_W'(BIN_W - 1)) begin
            bin_q   <= sr_d[BIN_W-1:0];
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_REJ: begin
          // Rejection completes one edge after the start; bin is left alone.
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bin  = bin_q;
  assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
// ============================================================================
// tb_bcd_to_bin_seq : directed + random self-checking bench for bcd_to_bin_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic [13:0] bin;
  logic        err;

  int errors = 0;
  int checks = 0;

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of four BCD digits by plain arithmetic.
  function automatic int ref_val(input int d3, input int d2, input int d1, input int d0);
    return d3 * 1000 + d2 * 100 + d1 * 10 + d0;
  endfunction

  // Called at a negedge; start is sampled on the following posedge.
  task automatic run_conv(input logic [15:0] b, input int exp, input string tag);
    int n;
    int nb;
    bcd   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd   = 16'(($urandom));
    n  = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 14);
    check({tag, "_busy_cycles"}, nb, 14);
    check({tag, "_bin"}, {18'd0, bin}, exp);
    check({tag, "_err"}, {31'd0, err}, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 0);
  endtask

  initial begin
    int n;
    int cnt;
    int d[4];
    rst_n = 1'b0;
    start = 1'b0;
    bcd   = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_bin",  {18'd0, bin},  0);
    check("rst_err",  {31'd0, err},  0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv(16'h0255, 255, "c0255");
    run_conv(16'h9999, 9999, "c9999");
    run_conv(16'h0000, 0, "c0000");

    // Back-to-back with start held: 0 then 1, done pulses 15 cycles apart.
    bcd   = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("b2b_first_latency", n, 14);
    check("b2b_first_bin", {18'd0, bin}, 0);
    bcd = 16'h0001;
    @(negedge clk);
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("b2b_gap", n, 15);
    check("b2b_second_bin", {18'd0, bin}, 1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_stop_busy", {31'd0, busy}, 0);

    // Second start while busy is ignored; bcd changes have no effect.
    bcd   = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); n++; end
    bcd   = 16'h4321;
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("ign_latency", n, 14);
    check("ign_bin", {18'd0, bin}, 1234);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("ign_no_second_done", cnt, 0);
    check("ign_bin_held", {18'd0, bin}, 1234);

    // Reset mid-conversion aborts without a done pulse.
    bcd   = 16'h0500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_bin",  {18'd0, bin},  0);
    check("abort_err",  {31'd0, err},  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort_no_activity", cnt, 0);

    // Random legal operands against the decimal reference.
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) d[k] = int'($urandom_range(0, 9));
      run_conv({4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])},
               ref_val(d[3], d[2], d[1], d[0]), $sformatf("rnd%0d", i));
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    run_conv(16'h0255, 255, "pre_rej");
    bcd   = 16'h12A4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = busy ? 1 : 0;
    check("rej_done_not_yet", {31'd0, done}, 0);
    @(negedge clk);
    if (busy) cnt++;
    check("rej_done", {31'd0, done}, 1);
    check("rej_err",  {31'd0, err},  1);
    check("rej_bin",  {18'd0, bin},  255);
    @(negedge clk);
    if (busy) cnt++;
    check("rej_done_pulse", {31'd0, done}, 0);
    check("rej_never_busy", cnt, 0);
    run_conv(16'h0042, 42, "post_rej");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
